fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entry count of the fetch queue (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc_in  input  32  current fetch address from the PC register.
REQ-005 SHALL have port flush  input  1  redirect (driven by PC_select); discards all wrong-path fetches.
REQ-006 SHALL have port stall  output  1  to PC; high means pc_in was not accepted this cycle and PC must hold.
REQ-007 SHALL have port imem_req_valid  output  1  instruction-memory request valid.
REQ-008 SHALL have port imem_req_addr  output  32  request address.
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-010 SHALL have port imem_resp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-011 SHALL have port imem_resp_data  input  32  fetched instruction word.
REQ-012 SHALL have port out_valid  output  1  decode-side instruction valid.
REQ-013 SHALL have port out_instr  output  32  instruction at queue head.
REQ-014 SHALL have port out_pc  output  32  address of out_instr.
REQ-015 SHALL have port out_ready  input  1  decode consumes head this cycle.

Function
REQ-016 SHALL keep count (allocated entries, 0..DEPTH) and discard_cnt (stale in-flight responses); credit = DEPTH - count - discard_cnt.
REQ-017 SHALL drive imem_req_valid = !rst && !flush && credit>0, imem_req_addr = pc_in (combinational, same cycle).
REQ-018 SHALL drive stall = !(imem_req_valid && imem_req_ready); stall is don't-care to PC in flush cycles.
REQ-019 SHALL on request acceptance allocate tail entry {pc=pc_in, filled=0}, tail pointer wraps modulo DEPTH.
REQ-020 SHALL on imem_resp_valid with discard_cnt>0 drop the response and decrement discard_cnt.
REQ-021 SHALL on imem_resp_valid with discard_cnt==0 write imem_resp_data into the oldest unfilled entry and set filled.
REQ-022 SHALL ignore imem_resp_valid when discard_cnt==0 and no unfilled entry exists.
REQ-023 SHALL drive out_valid = head filled && count>0 && !flush; out_instr/out_pc from head entry.
REQ-024 SHALL pop head on out_valid && out_ready; allocate and pop in the same cycle leave count unchanged.
REQ-025 SHALL bypass nothing: minimum fetch-to-out_valid latency is 1 cycle after response capture (response in cycle N, out_valid in N+1).
REQ-026 SHALL on flush clear all entries, count, pointers; set discard_cnt <= discard_cnt + (unfilled entries) - (1 if imem_resp_valid this cycle else 0).
REQ-027 SHALL when count==DEPTH (credit 0) hold imem_req_valid low and stall high until a pop or flush frees credit.
REQ-028 SHALL keep pointers log2(DEPTH) bits, count and discard_cnt log2(DEPTH)+1 bits; count+discard_cnt never exceeds DEPTH.

Reset
REQ-029 SHALL on rst: count=0, discard_cnt=0, pointers=0, all filled=0, out_valid=0, imem_req_valid=0, stall=1.
REQ-030 SHALL give rst priority over flush, requests, responses and pops in the same cycle; memory is reset together with this block.

Verification
REQ-031 Basic stream: pc 0,4,8, ready=1, resp latency 1, out_ready=1 -> out_pc 0,4,8 in order, instr matches, stall=0 throughout.
REQ-032 Full queue: DEPTH=4, out_ready=0, 4 requests accepted -> 5th cycle imem_req_valid=0, stall=1; one pop -> request 0x10 issued next cycle.
REQ-033 Flush with 2 in flight: flush cycle, no resp -> discard_cnt=2, next 2 responses dropped, target-path instruction is first out_valid.
REQ-034 Flush coincident with response: 2 unfilled, resp_valid in flush cycle -> discard_cnt=1; exactly one later response dropped.
REQ-035 Memory backpressure: imem_req_ready=0 for 3 cycles -> stall=1 for 3 cycles, pc_in held, no entry allocated.
REQ-036 Reset mid-operation: 3 entries filled, rst 1 cycle -> out_valid=0, count=0, stall=1 during rst; fetch resumes at pc 0 after.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - fetch-side bundle: PC handshake, imem request/response, decode stream
//
// Signals
//   pc_in           PC -> buffer   current fetch address
//   flush           PC_select      redirect, drop wrong-path work
//   stall           buffer -> PC   pc_in not accepted, hold PC
//   imem_req_*      buffer -> imem request valid/addr, ready from imem
//   imem_resp_*     imem -> buffer in-order response valid/data
//   out_*           buffer <-> decode, valid/instr/pc out, ready in
// Modports: slave = the fetch buffer, master = the surrounding pipeline/memory.
interface fetch_buffer_if;
    logic [31:0] pc_in;
    logic        flush;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    modport slave (
        input  pc_in, flush, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
        output stall, imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
    );

    modport master (
        output pc_in, flush, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
        input  stall, imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order instruction fetch queue between PC, imem and decode
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset (imem is reset alongside)
//   fb   fetch_buffer_if.slave: pc_in/flush/stall, imem_req_*, imem_resp_*, out_*
// Parameter DEPTH: queue entries, power of two in 2..16.
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fetch_buffer_if.slave  fb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;

    // fill_q tracks the oldest unfilled entry; responses arrive in request
    // order, so filled entries always form a contiguous run from head_q.
    logic [PW-1:0] head_q, tail_q, fill_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] pend_q;      // allocated but still unfilled entries
    logic [CW-1:0] discard_q;   // stale responses still owed by imem

    logic          req_valid;
    logic          out_valid;
    logic          alloc;
    logic          pop;
    logic          resp_drop;
    logic          resp_fill;
    logic [CW:0]   flush_sum;
    logic [CW-1:0] flush_discard;

    // Stale responses reserve queue slots too, so credit is DEPTH minus both.
    always_comb begin
        req_valid = !rst && !fb.flush && ({1'b0, count_q} + {1'b0, discard_q} < (CW+1)'(DEPTH));
        out_valid = !rst && !fb.flush && (count_q != '0) && filled_q[head_q];
        alloc     = req_valid && fb.imem_req_ready;
        pop       = out_valid && fb.out_ready;
        resp_drop = fb.imem_resp_valid && (discard_q != '0);
        resp_fill = fb.imem_resp_valid && (discard_q == '0) && (pend_q != '0);
    end

    // On redirect every unfilled entry becomes a stale response; one arriving
    // in the flush cycle itself is already retired. A response with nothing
    // owed is ignored, hence the zero guard.
    always_comb begin
        flush_sum     = {1'b0, discard_q} + {1'b0, pend_q};
        flush_discard = CW'(flush_sum);
        if (fb.imem_resp_valid && (flush_sum != '0)) begin
            flush_discard = CW'(flush_sum - 1'b1);
        end
    end

    always_comb begin
        fb.imem_req_valid = req_valid;
        fb.imem_req_addr  = fb.pc_in;
        fb.stall          = !alloc;
        fb.out_valid      = out_valid;
        fb.out_instr      = instr_q[head_q];
        fb.out_pc         = pc_q[head_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            discard_q <= '0;
            filled_q  <= '0;
        end else if (fb.flush) begin
            head_q    <= '0;
            tail_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            discard_q <= flush_discard;
            filled_q  <= '0;
        end else begin
            // tail_q and fill_q never coincide: alloc needs a free slot,
            // fill targets an allocated one.
            if (alloc) begin
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + 1'b1;
            end
            if (resp_fill) begin
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + 1'b1;
            end
            if (resp_drop) begin
                discard_q <= discard_q - 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(alloc) - CW'(pop);
            pend_q  <= pend_q + CW'(alloc) - CW'(resp_fill);
        end
    end

    // Payload storage carries no reset; validity lives in filled_q/count_q.
    always_ff @(posedge clk) begin
        if (!rst && !fb.flush) begin
            if (alloc) begin
                pc_q[tail_q] <= fb.pc_in;
            end
            if (resp_fill) begin
                instr_q[fill_q] <= fb.imem_resp_data;
            end
        end
    end
endmodule
